// File: rtl/sha1_pad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sha1_pad_pkg                                                  |
// | Desc     : Shared types, constants and byte helpers for the SHA-1 padder |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package sha1_pad_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FILL  = 4'd1,
        ST_PAD   = 4'd2,
        ST_LEN   = 4'd3,
        ST_ISSUE = 4'd4,
        ST_WAIT  = 4'd5,
        ST_FIN   = 4'd6,
        ST_DONE  = 4'd7
    } state_t;

    localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
    localparam int          BLOCK_WORDS = 16;
    localparam logic [3:0]  LEN_HI_IDX  = 4'd14;
    localparam logic [3:0]  LEN_LO_IDX  = 4'd15;

    // Keep-mask for the first n bytes of a big-endian word, n in 0..4.
    function automatic logic [31:0] byte_mask(input logic [2:0] n);
        case (n)
            3'd0:    byte_mask = 32'h0000_0000;
            3'd1:    byte_mask = 32'hFF00_0000;
            3'd2:    byte_mask = 32'hFFFF_0000;
            3'd3:    byte_mask = 32'hFFFF_FF00;
            default: byte_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // 0x80 marker placed in byte n; nothing when the word is full.
    function automatic logic [31:0] pad_marker(input logic [2:0] n);
        case (n)
            3'd0:    pad_marker = PAD_WORD;
            3'd1:    pad_marker = 32'h0080_0000;
            3'd2:    pad_marker = 32'h0000_8000;
            3'd3:    pad_marker = 32'h0000_0080;
            default: pad_marker = 32'h0000_0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha1_pad_word.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sha1_pad_word                                                 |
// | Desc     : Masks unused bytes of a final word and inserts the 0x80 byte  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sha1_pad_word
    import sha1_pad_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_bytes,
    output logic [31:0] o_word,
    output logic [2:0]  o_nbytes,
    output logic        o_pad_inserted
);

    logic [2:0] w_n;

    assign w_n            = (i_bytes > 3'd4) ? 3'd4 : i_bytes;
    assign o_word         = (i_data & byte_mask(w_n)) | pad_marker(w_n);
    assign o_nbytes       = w_n;
    assign o_pad_inserted = (w_n != 3'd4);

endmodule
`default_nettype wire

// File: rtl/sha1_msg_padder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sha1_msg_padder                                               |
// | Desc     : Word-stream SHA-1 padder feeding 512-bit blocks to sha1_core  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sha1_msg_padder
    import sha1_pad_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         sha_reset,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         in_ready,
    input  logic         sha_core_ready,
    input  logic [159:0] sha_core_digest,
    input  logic         sha_core_digest_valid,
    output logic         sha_init,
    output logic         sha_next,
    output logic [511:0] sha_block,
    output logic [159:0] sha_hash,
    output logic         hash_valid,
    output logic         busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_block [BLOCK_WORDS];
    logic [3:0]         r_ctr;
    logic [LEN_W-1:0]   r_len;
    logic               r_first;
    logic               r_last_seen;
    logic               r_pad_done;
    logic               r_len_done;
    logic               r_wait_skip;
    logic [159:0]       r_hash;
    logic               r_hash_valid;

    logic [31:0]        w_last_word;
    logic [2:0]         w_nbytes;
    logic               w_pad_ins;
    logic               w_accept;
    logic               w_start;
    logic [LEN_W-1:0]   w_len_base;
    logic [LEN_W-1:0]   w_len_add;
    logic [63:0]        w_len64;
    logic               w_pad_to_len;

    sha1_pad_word u_pad_word (
        .i_data         (in_data),
        .i_bytes        (in_bytes),
        .o_word         (w_last_word),
        .o_nbytes       (w_nbytes),
        .o_pad_inserted (w_pad_ins)
    );

    assign in_ready     = (r_state == ST_IDLE) || (r_state == ST_FILL) || (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_accept     = in_valid && in_ready;
    assign w_start      = w_accept && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_len_base   = w_start ? '0 : r_len;
    assign w_len_add    = in_last ? LEN_W'({w_nbytes, 3'b000}) : LEN_W'(32);
    assign w_len64      = 64'(r_len);
    assign w_pad_to_len = (r_ctr == LEN_HI_IDX) && r_pad_done;
    assign sha_init     = (r_state == ST_ISSUE) && sha_core_ready && r_first;
    assign sha_next     = (r_state == ST_ISSUE) && sha_core_ready && !r_first;
    assign sha_hash     = r_hash;
    assign hash_valid   = r_hash_valid;

    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_block_out
        assign sha_block[511-32*gi -: 32] = r_block[gi];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FILL: begin
                if (w_accept) begin
                    if (r_ctr == LEN_LO_IDX) w_state_next = ST_ISSUE;
                    else if (in_last)        w_state_next = ST_PAD;
                    else                     w_state_next = ST_FILL;
                end
            end
            ST_PAD: begin
                if (w_pad_to_len)              w_state_next = ST_LEN;
                else if (r_ctr == LEN_LO_IDX)  w_state_next = ST_ISSUE;
            end
            ST_LEN:   w_state_next = ST_ISSUE;
            ST_ISSUE: if (sha_core_ready) w_state_next = ST_WAIT;
            ST_WAIT: begin
                // The core only drops ready the cycle after the pulse, so skip one sample.
                if (!r_wait_skip && sha_core_ready) begin
                    if (!r_last_seen)     w_state_next = ST_FILL;
                    else if (!r_len_done) w_state_next = ST_PAD;
                    else                  w_state_next = ST_FIN;
                end
            end
            ST_FIN: if (sha_core_digest_valid && sha_core_ready) w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sha_reset) begin
            r_state      <= ST_IDLE;
            r_ctr        <= '0;
            r_len        <= '0;
            r_first      <= 1'b1;
            r_last_seen  <= 1'b0;
            r_pad_done   <= 1'b0;
            r_len_done   <= 1'b0;
            r_wait_skip  <= 1'b0;
            r_hash       <= '0;
            r_hash_valid <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) r_block[i] <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE, ST_DONE, ST_FILL: begin
                    if (w_accept) begin
                        r_block[r_ctr] <= in_last ? w_last_word : in_data;
                        r_ctr          <= r_ctr + 4'd1;
                        r_len          <= w_len_base + w_len_add;
                        r_last_seen    <= in_last;
                        r_pad_done     <= in_last && w_pad_ins;
                        if (w_start) begin
                            r_first      <= 1'b1;
                            r_len_done   <= 1'b0;
                            r_hash_valid <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    if (!w_pad_to_len) begin
                        r_block[r_ctr] <= r_pad_done ? 32'h0 : PAD_WORD;
                        r_pad_done     <= 1'b1;
                        r_ctr          <= r_ctr + 4'd1;
                    end
                end
                ST_LEN: begin
                    r_block[LEN_HI_IDX] <= w_len64[63:32];
                    r_block[LEN_LO_IDX] <= w_len64[31:0];
                    r_len_done          <= 1'b1;
                end
                ST_ISSUE: begin
                    if (sha_core_ready) begin
                        r_first     <= 1'b0;
                        r_wait_skip <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_skip) begin
                        r_wait_skip <= 1'b0;
                    end else if (sha_core_ready) begin
                        r_ctr <= '0;
                        for (int i = 0; i < BLOCK_WORDS; i++) r_block[i] <= '0;
                    end
                end
                ST_FIN: begin
                    if (sha_core_digest_valid && sha_core_ready) begin
                        r_hash       <= sha_core_digest;
                        r_hash_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
